aes_cipher_arbiter: RTL and testbench
=====================================

# aes_cipher_arbiter

Shares one AesCipher datapath (128-bit block, 128-bit key, fixed latency) between two requesters. Each requester presents a plaintext block and key on a valid/ready handshake. The arbiter grants round-robin, registers the winning operands onto the cipher inputs and tracks in-flight requester IDs through a tag pipeline matched to the cipher latency. It then returns each ciphertext on the originating requester's response port, sustaining one block per cycle.

## Interface
- CIPHER_LAT, 0, cycles from stable `aes_datain`/`aes_key` to valid `aes_dataout` (0 = combinational cipher); legal range 0..15
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset; synchronous and active-high
- req0_valid  in  1  requester 0 has a block to encrypt
- req0_ready  out  1  requester 0 granted this cycle
- req0_data  in  128  requester 0 plaintext block
- req0_key  in  128  requester 0 cipher key
- req1_valid, req1_ready, req1_data, req1_key: same as requester 0, for requester 1
- aes_datain  out  128  to cipher `datain`
- aes_key  out  128  to cipher `key`
- aes_dataout  in  128  from cipher `dataout`
- rsp0_valid  out  1  one-cycle pulse: `rsp0_data` holds requester 0 result
- rsp0_data  out  128  ciphertext for requester 0
- rsp1_valid, rsp1_data: same as requester 0, for requester 1

## Operation
- Handshake: a transfer occurs when `reqN_valid & reqN_ready`. A requester holds valid/data/key stable until ready. Ready is combinational from both valids and the `last` register; it never depends on the requester's own ready.
- Arbitration, two-way round-robin with a `last` register (1 bit, ID of the most recent grant):
  - only one valid: grant it;
  - both valid: grant `~last`;
  - neither valid: no grant, `last` unchanged.
- `last` updates to the granted ID on every grant. Reset value is 1, so requester 0 wins the first contention.
- Issue stage: on a grant, the winner's data/key are registered into `aes_datain`/`aes_key` and an issue tag {valid=1, id} is registered. With no grant, the tag valid is 0 and `aes_datain`/`aes_key` hold their last values (no toggling).
- Tag pipeline: the issue tag shifts through CIPHER_LAT further stages. The tag at the output of the last stage is aligned with `aes_dataout`.
- Response stage: when the aligned tag is valid, `aes_dataout` is registered into `rspN_data` for id N and `rspN_valid` pulses for one cycle. The other response port's data holds.
- There is no response backpressure. Requesters must accept a response the cycle it is valid.
- Responses return in grant order.
- Reset, including mid-operation: every tag valid is cleared, so in-flight blocks are dropped and produce no response. `rsp*_valid` = 0, `rsp*_data` = 0, `aes_datain` = 0, `aes_key` = 0, `last` = 1. `req*_ready` depends only on the valid inputs and is 0 while both valids are 0.
- Keys are per request: back-to-back grants with different keys are legal.

## Timing
- Grant at edge t (handshake in the cycle before t):
  - `aes_datain`/`aes_key` valid after t;
  - result captured at edge t+1+CIPHER_LAT;
  - `rspN_valid` high in the cycle after edge t+1+CIPHER_LAT.
- Handshake-to-response latency is CIPHER_LAT+2 cycles. With CIPHER_LAT = 0 it is 2 cycles.
- Throughput: one grant per cycle regardless of ID. Both requesters held valid alternate 0,1,0,1,...
- At most one response pulse per cycle across both ports.
- Up to CIPHER_LAT+2 blocks in flight; no internal limit.

## Structure
- Shared package `aes_pkg`: BLOCK_W = 128, KEY_W = 128, requester-ID type (1 bit), tag struct {valid, id}.
- One sub-module: `rr_arb2`, a two-input round-robin arbiter holding the `last` register and producing grant bits.
- Tag pipeline and operand/response registers live in the top module. The cipher is instantiated outside this block.

## Test plan
- FIPS-197 vector, CIPHER_LAT = 0:
  - stimulus: req0 key 000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff;
  - required: `rsp0_valid` exactly 2 cycles after the handshake, `rsp0_data` = 69c4e0d86a7b0430d8cdb78070b4c55a, `rsp1_valid` stays 0.
- Contention:
  - stimulus: both requesters valid continuously for 6 cycles, key 11111111222222223333333344444444, req0 data 10101010202020203030303040404040, req1 data = req0 data + 1;
  - required: grants 0,1,0,1,0,1; responses return alternating on rsp0/rsp1 with ciphertexts matching the reference model.
- Latency sweep:
  - stimulus: CIPHER_LAT = 3 with a registered-model cipher, streaming 8 back-to-back blocks on req1;
  - required: each `rsp1_valid` arrives 5 cycles after its handshake, with no gaps.
- Reset mid-operation:
  - stimulus: issue 2 blocks, assert `rst` 1 cycle later;
  - required: no response pulses for those blocks, all outputs 0, `last` = 1 (first post-reset contention goes to req0).
- Held-valid stability:
  - stimulus: req1 valid while req0 wins repeatedly;
  - required: req1 is granted the next cycle (no starvation) and `aes_datain` does not change on idle cycles.

Source files
------------

// File: rtl/aes_cipher_arbiter_pkg.sv
// Shared types for the two-requester AES cipher arbiter:
// datapath widths, requester ID and the in-flight tag.
package aes_pkg;

    localparam int BLOCK_W = 128;
    localparam int KEY_W   = 128;

    typedef logic req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } tag_t;

endpackage

// File: rtl/aes_cipher_arbiter_if.sv
// Requester-side bundle: request handshake with plaintext/key
// and the one-cycle response pulse carrying the ciphertext.
interface aes_cipher_arbiter_if;
    import aes_pkg::*;

    logic               valid;
    logic               ready;
    logic [BLOCK_W-1:0] data;
    logic [KEY_W-1:0]   key;
    logic               rsp_valid;
    logic [BLOCK_W-1:0] rsp_data;

    modport master (
        output valid, data, key,
        input  ready, rsp_valid, rsp_data
    );

    modport slave (
        input  valid, data, key,
        output ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/aes_cipher_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; last_q remembers the most
// recent winner so contention alternates between requesters.
module rr_arb2
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    req_id_t last_q;
    req_id_t last_d;

    // Lone requester wins; on contention the one not served last wins
    always_comb begin
        gnt_o  = 2'b00;
        last_d = last_q;
        unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
        if (gnt_o[1]) begin
            last_d = 1'b1;
        end else if (gnt_o[0]) begin
            last_d = 1'b0;
        end
    end

    // Reset to 1 so requester 0 wins the first contention
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/aes_cipher_arbiter.sv
// Shares one fixed-latency AES datapath between two requesters:
// round-robin issue, tag pipeline, per-requester response pulse.
module aes_cipher_arbiter
    import aes_pkg::*;
#(
    parameter int CIPHER_LAT = 0
) (
    input  logic                clk,
    input  logic                rst,
    aes_cipher_arbiter_if.slave req0,
    aes_cipher_arbiter_if.slave req1,
    output logic [BLOCK_W-1:0]  aes_datain,
    output logic [KEY_W-1:0]    aes_key,
    input  logic [BLOCK_W-1:0]  aes_dataout
);

    logic [1:0]         gnt;
    tag_t               tag_d;
    tag_t               tag_q [CIPHER_LAT+1];
    tag_t               tag_al;
    logic [BLOCK_W-1:0] datain_d, datain_q;
    logic [KEY_W-1:0]   key_d, key_q;
    logic               rsp0_valid_d, rsp0_valid_q;
    logic               rsp1_valid_d, rsp1_valid_q;
    logic [BLOCK_W-1:0] rsp0_data_d, rsp0_data_q;
    logic [BLOCK_W-1:0] rsp1_data_d, rsp1_data_q;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_i ({req1.valid, req0.valid}),
        .gnt_o (gnt)
    );

    assign req0.ready     = gnt[0];
    assign req1.ready     = gnt[1];
    assign aes_datain     = datain_q;
    assign aes_key        = key_q;
    assign req0.rsp_valid = rsp0_valid_q;
    assign req0.rsp_data  = rsp0_data_q;
    assign req1.rsp_valid = rsp1_valid_q;
    assign req1.rsp_data  = rsp1_data_q;
    assign tag_al         = tag_q[CIPHER_LAT];

    // Load the winner's operands; idle cycles keep cipher inputs still
    always_comb begin
        datain_d = datain_q;
        key_d    = key_q;
        tag_d    = '0;
        if (gnt[1]) begin
            datain_d    = req1.data;
            key_d       = req1.key;
            tag_d.valid = 1'b1;
            tag_d.id    = 1'b1;
        end else if (gnt[0]) begin
            datain_d    = req0.data;
            key_d       = req0.key;
            tag_d.valid = 1'b1;
            tag_d.id    = 1'b0;
        end
    end

    // Route the cipher output to the port named by the aligned tag
    always_comb begin
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
        rsp0_data_d  = rsp0_data_q;
        rsp1_data_d  = rsp1_data_q;
        if (tag_al.valid) begin
            if (tag_al.id) begin
                rsp1_valid_d = 1'b1;
                rsp1_data_d  = aes_dataout;
            end else begin
                rsp0_valid_d = 1'b1;
                rsp0_data_d  = aes_dataout;
            end
        end
    end

    // Tag shift register; depth tracks the cipher latency
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= CIPHER_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= tag_d;
            for (int i = 1; i <= CIPHER_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    // Operand and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            datain_q     <= '0;
            key_q        <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_data_q  <= '0;
            rsp1_data_q  <= '0;
        end else begin
            datain_q     <= datain_d;
            key_q        <= key_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_data_q  <= rsp0_data_d;
            rsp1_data_q  <= rsp1_data_d;
        end
    end

endmodule

// File: tb/tb_aes_cipher_arbiter.sv
// Directed bench: one arbiter with a combinational AES model,
// one with a three-stage registered AES model.
module tb_aes_cipher_arbiter;

    localparam logic [127:0] FIPS_K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_D = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CK     = 128'h11111111222222223333333344444444;
    localparam logic [127:0] CD0    = 128'h10101010202020203030303040404040;
    localparam logic [127:0] CD1    = 128'h10101010202020203030303040404041;
    localparam logic [127:0] SB     = 128'hcafef00d000000000000000012345600;
    localparam logic [127:0] SK     = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    localparam logic [127:0] H0     = 128'h00000000000000000000000000000a00;
    localparam logic [127:0] H1     = 128'h00000000000000000000000000000a01;
    localparam logic [127:0] H2     = 128'h00000000000000000000000000000a02;
    localparam logic [127:0] HY     = 128'h0000000000000000000000000000b000;
    localparam logic [127:0] HK0    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] HK1    = 128'h5555aaaa5555aaaa5555aaaa5555aaaa;

    // ---------------- AES-128 reference ----------------
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sb(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] q;
        logic [7:0] e;
        r = 8'h01;
        q = a;
        e = 8'hfe;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gm(r, q);
            q = gm(q, q);
        end
        return r ^ rl(r, 1) ^ rl(r, 2) ^ rl(r, 3) ^ rl(r, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes128(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb(tmp[23:16]), sb(tmp[15:8]), sb(tmp[7:0]), sb(tmp[31:24])}
                      ^ {rc, 24'h000000};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sb(s[i]);
            for (int c = 0; c < 4; c++) begin
                for (int q = 0; q < 4; q++) t[q+4*c] = s[q+4*((c+q)%4)];
            end
            if (r != 10) begin
                for (int c = 0; c < 4; c++) begin
                    s[4*c]   = gm(t[4*c], 8'h02) ^ gm(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gm(t[4*c+1], 8'h02) ^ gm(t[4*c+2], 8'h03) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gm(t[4*c+2], 8'h02) ^ gm(t[4*c+3], 8'h03);
                    s[4*c+3] = gm(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gm(t[4*c+3], 8'h02);
                end
            end else begin
                for (int i = 0; i < 16; i++) s[i] = t[i];
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- DUTs and cipher models ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_cipher_arbiter_if a0 ();
    aes_cipher_arbiter_if a1 ();
    aes_cipher_arbiter_if b0 ();
    aes_cipher_arbiter_if b1 ();

    logic [127:0] a_din, a_key, a_dout;
    logic [127:0] b_din, b_key, b_dout;
    logic [127:0] b_s1, b_s2, b_s3;

    aes_cipher_arbiter #(.CIPHER_LAT(0)) u_dut_a (
        .clk         (clk),
        .rst         (rst),
        .req0        (a0),
        .req1        (a1),
        .aes_datain  (a_din),
        .aes_key     (a_key),
        .aes_dataout (a_dout)
    );

    aes_cipher_arbiter #(.CIPHER_LAT(3)) u_dut_b (
        .clk         (clk),
        .rst         (rst),
        .req0        (b0),
        .req1        (b1),
        .aes_datain  (b_din),
        .aes_key     (b_key),
        .aes_dataout (b_dout)
    );

    assign a_dout = aes128(a_din, a_key);

    always @(posedge clk) begin
        b_s1 <= aes128(b_din, b_key);
        b_s2 <= b_s1;
        b_s3 <= b_s2;
    end
    assign b_dout = b_s3;

    // ---------------- event recorder ----------------
    typedef struct {
        int           cyc;
        logic         id;
        logic [127:0] d;
    } ev_t;

    ev_t hs_a[$];
    ev_t rs_a[$];
    ev_t hs_b[$];
    ev_t rs_b[$];
    int  cyc = 0;
    int  dual = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (a0.valid && a0.ready) hs_a.push_back('{cyc, 1'b0, a0.data});
        if (a1.valid && a1.ready) hs_a.push_back('{cyc, 1'b1, a1.data});
        if (b0.valid && b0.ready) hs_b.push_back('{cyc, 1'b0, b0.data});
        if (b1.valid && b1.ready) hs_b.push_back('{cyc, 1'b1, b1.data});
        if (a0.rsp_valid) rs_a.push_back('{cyc, 1'b0, a0.rsp_data});
        if (a1.rsp_valid) rs_a.push_back('{cyc, 1'b1, a1.rsp_data});
        if (b0.rsp_valid) rs_b.push_back('{cyc, 1'b0, b0.rsp_data});
        if (b1.rsp_valid) rs_b.push_back('{cyc, 1'b1, b1.rsp_data});
        if ((a0.rsp_valid && a1.rsp_valid) || (b0.rsp_valid && b1.rsp_valid)) dual <= dual + 1;
    end

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        a0.valid = 1'b0; a1.valid = 1'b0;
        b0.valid = 1'b0; b1.valid = 1'b0;
    endtask

    task automatic do_reset();
        idle_all();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        hs_a.delete(); rs_a.delete();
        hs_b.delete(); rs_b.delete();
    endtask

    logic [5:0]   pat6;
    logic [3:0]   pat4;
    logic [127:0] exp_ct;

    initial begin
        idle_all();
        a0.data = '0; a0.key = '0; a1.data = '0; a1.key = '0;
        b0.data = '0; b0.key = '0; b1.data = '0; b1.key = '0;
        rst = 1'b1;
        #1;
        do_reset();

        // reset state
        chk("rst_a_din", a_din, '0);
        chk("rst_a_key", a_key, '0);
        chk("rst_a_rsp0_v", a0.rsp_valid, 0);
        chk("rst_a_rsp1_d", a1.rsp_data, '0);
        chk("rst_a_rdy0", a0.ready, 0);
        chk("rst_b_din", b_din, '0);

        // FIPS-197 vector through the zero-latency path
        a0.data = FIPS_D; a0.key = FIPS_K; a0.valid = 1'b1;
        tick();
        a0.valid = 1'b0;
        repeat (6) tick();
        chk("fips_hs_n", hs_a.size(), 1);
        chk("fips_rsp_n", rs_a.size(), 1);
        if (hs_a.size() == 1 && rs_a.size() == 1) begin
            chk("fips_lat", rs_a[0].cyc - hs_a[0].cyc, 2);
            chk("fips_id", rs_a[0].id, 0);
            chk("fips_ct", rs_a[0].d, FIPS_C);
        end

        // Contention: both valid for six cycles
        do_reset();
        a0.data = CD0; a0.key = CK; a1.data = CD1; a1.key = CK;
        a0.valid = 1'b1; a1.valid = 1'b1;
        repeat (6) tick();
        idle_all();
        repeat (6) tick();
        chk("cont_hs_n", hs_a.size(), 6);
        chk("cont_rsp_n", rs_a.size(), 6);
        if (hs_a.size() == 6 && rs_a.size() == 6) begin
            pat6 = '0;
            for (int i = 0; i < 6; i++) pat6[i] = hs_a[i].id;
            chk("cont_grants", pat6, 6'b101010);
            for (int i = 0; i < 6; i++) pat6[i] = rs_a[i].id;
            chk("cont_rsp_ids", pat6, 6'b101010);
            for (int i = 0; i < 6; i++) begin
                exp_ct = (i % 2 == 1) ? aes128(CD1, CK) : aes128(CD0, CK);
                chk($sformatf("cont_ct%0d", i), rs_a[i].d, exp_ct);
                chk($sformatf("cont_lat%0d", i), rs_a[i].cyc - hs_a[i].cyc, 2);
            end
        end

        // Latency sweep: 8 back-to-back blocks on req1, 3-cycle cipher
        do_reset();
        for (int i = 0; i < 8; i++) begin
            b1.data = SB + 128'(i);
            b1.key = SK ^ 128'(i);
            b1.valid = 1'b1;
            tick();
        end
        idle_all();
        repeat (10) tick();
        chk("sweep_hs_n", hs_b.size(), 8);
        chk("sweep_rsp_n", rs_b.size(), 8);
        if (hs_b.size() == 8 && rs_b.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                exp_ct = aes128(SB + 128'(i), SK ^ 128'(i));
                chk($sformatf("sweep_lat%0d", i), rs_b[i].cyc - hs_b[i].cyc, 5);
                chk($sformatf("sweep_gap%0d", i), rs_b[i].cyc - rs_b[0].cyc, i);
                chk($sformatf("sweep_id%0d", i), rs_b[i].id, 1);
                chk($sformatf("sweep_ct%0d", i), rs_b[i].d, exp_ct);
            end
        end

        // Reset while two blocks are in flight
        hs_b.delete(); rs_b.delete();
        b0.key = CK;
        b0.data = CD0; b0.valid = 1'b1;
        tick();
        b0.data = CD1;
        tick();
        b0.valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("mrst_hs_n", hs_b.size(), 2);
        chk("mrst_rsp0_v", b0.rsp_valid, 0);
        chk("mrst_rsp0_d", b0.rsp_data, '0);
        chk("mrst_rsp1_d", b1.rsp_data, '0);
        chk("mrst_din", b_din, '0);
        chk("mrst_key", b_key, '0);
        chk("mrst_rdy0", b0.ready, 0);
        repeat (8) tick();
        chk("mrst_no_rsp", rs_b.size(), 0);
        b0.valid = 1'b1; b1.valid = 1'b1;
        #1;
        chk("mrst_first_rdy0", b0.ready, 1);
        chk("mrst_first_rdy1", b1.ready, 0);
        tick();
        idle_all();
        repeat (6) tick();

        // Held-valid stability on the zero-latency path
        do_reset();
        a0.key = HK0; a1.key = HK1; a1.data = HY;
        a0.data = H0; a0.valid = 1'b1;
        tick();
        a0.data = H1;
        tick();
        a0.data = H2; a1.valid = 1'b1;
        #1;
        chk("held_rdy1", a1.ready, 1);
        tick();
        a1.valid = 1'b0;
        tick();
        a0.valid = 1'b0;
        a0.data = 128'hdead;
        #1;
        chk("held_din0", a_din, H2);
        repeat (3) tick();
        chk("held_din3", a_din, H2);
        chk("held_key3", a_key, HK0);
        chk("held_hs_n", hs_a.size(), 4);
        if (hs_a.size() == 4) begin
            pat4 = '0;
            for (int i = 0; i < 4; i++) pat4[i] = hs_a[i].id;
            chk("held_grants", pat4, 4'b0100);
        end
        chk("held_rsp_n", rs_a.size(), 4);
        if (rs_a.size() == 4) begin
            chk("held_ct_y", rs_a[2].d, aes128(HY, HK1));
            chk("held_ct_h2", rs_a[3].d, aes128(H2, HK0));
        end

        chk("dual_rsp", dual, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
